atm_account_ledger: RTL and testbench

Multi-account successor to the single-balance deposit/withdraw counter. Holds NUM_ACCT balances of WIDTH bits and executes one transaction at a time: deposit, withdraw, query or transfer. Transactions enter through a valid/ready request channel and leave through a valid/ready response channel. Sits between the ATM keypad/menu controller and the display/LED driver.

---
 rtl/atm_pkg.sv | 27 ++
 rtl/atm_txn_check.sv | 72 +++++++
 rtl/atm_account_ledger.sv | 156 +++++++++++++++
 tb/tb_atm_account_ledger.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/atm_pkg.sv
// Shared types for the ATM account ledger: transaction opcodes, response
// status codes and the transaction sequencer states.
// Imported by atm_txn_check and atm_account_ledger.
package atm_pkg;

  typedef enum logic [1:0] {
    OP_DEPOSIT  = 2'd0,
    OP_WITHDRAW = 2'd1,
    OP_QUERY    = 2'd2,
    OP_TRANSFER = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_OK           = 3'd0,
    ST_OVERFLOW     = 3'd1,
    ST_INSUFFICIENT = 3'd2,
    ST_BAD_ACCT     = 3'd3,
    ST_LIMIT        = 3'd4
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/atm_txn_check.sv
// Purpose: validates one ledger transaction and computes post-op balances.
// Latency: purely combinational, no state.
// Backpressure: none; the caller decides when to commit the results.
// Ports: op/amount, src_bal/dst_bal, wd_cnt (source withdrawal count),
//   src_ok/dst_ok (ids in range), same_acct (dst == src) in;
//   status, new_src, new_dst, cnt_inc (source counter must advance) out.
module atm_txn_check
  import atm_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MAX_WD = 3,
  parameter int CW     = 2
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] src_bal,
  input  logic [WIDTH-1:0] dst_bal,
  input  logic [WIDTH-1:0] amount,
  input  logic [CW-1:0]    wd_cnt,
  input  logic             src_ok,
  input  logic             dst_ok,
  input  logic             same_acct,
  output status_e          status,
  output logic [WIDTH-1:0] new_src,
  output logic [WIDTH-1:0] new_dst,
  output logic             cnt_inc
);

  logic             is_debit;
  logic [WIDTH:0]   sum_src;
  logic [WIDTH:0]   sum_dst;

  assign is_debit = (op == OP_WITHDRAW) || (op == OP_TRANSFER);
  // One extra bit so the carry out flags an overflow instead of wrapping.
  assign sum_src  = {1'b0, src_bal} + {1'b0, amount};
  assign sum_dst  = {1'b0, dst_bal} + {1'b0, amount};

  always_comb begin
    status  = ST_OK;
    new_src = src_bal;
    new_dst = dst_bal;
    cnt_inc = 1'b0;
    if (!src_ok || ((op == OP_TRANSFER) && !dst_ok)) begin
      status = ST_BAD_ACCT;
    end else if (is_debit && (wd_cnt == CW'(MAX_WD))) begin
      status = ST_LIMIT;
    end else if (is_debit && (amount > src_bal)) begin
      status = ST_INSUFFICIENT;
    end else if ((op == OP_DEPOSIT) && sum_src[WIDTH]) begin
      status = ST_OVERFLOW;
    end else if ((op == OP_TRANSFER) && !same_acct && sum_dst[WIDTH]) begin
      status = ST_OVERFLOW;
    end else begin
      case (op)
        OP_DEPOSIT:  new_src = sum_src[WIDTH-1:0];
        OP_WITHDRAW: begin
          new_src = src_bal - amount;
          cnt_inc = 1'b1;
        end
        OP_TRANSFER: begin
          // A self-transfer moves no money but still consumes a withdrawal.
          if (!same_acct) begin
            new_src = src_bal - amount;
            new_dst = sum_dst[WIDTH-1:0];
          end
          cnt_inc = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/atm_account_ledger.sv
// Purpose: multi-account balance ledger executing deposit/withdraw/query/transfer.
// Latency: request accepted at edge N, response valid after edge N+1; one txn per 3 cycles peak.
// Backpressure: txn_ready only in IDLE; response held stable until resp_ready handshake.
// Ports: clk, rst (async, active-high); txn_valid/txn_ready/txn_op/txn_acct/
//   txn_dst/txn_amount request channel; day_clear pulse; resp_valid/resp_ready/
//   resp_status/resp_balance response channel; led_ovf/led_insuf sticky LEDs.
module atm_account_ledger
  import atm_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int NUM_ACCT = 4,
  parameter  int MAX_WD   = 3,
  localparam int AW       = $clog2(NUM_ACCT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             txn_valid,
  output logic             txn_ready,
  input  logic [1:0]       txn_op,
  input  logic [AW-1:0]    txn_acct,
  input  logic [AW-1:0]    txn_dst,
  input  logic [WIDTH-1:0] txn_amount,
  input  logic             day_clear,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [2:0]       resp_status,
  output logic [WIDTH-1:0] resp_balance,
  output logic             led_ovf,
  output logic             led_insuf
);

  localparam int CW = $clog2(MAX_WD + 1);

  state_e           state_q, state_d;
  op_e              op_q;
  logic [AW-1:0]    acct_q, dst_q;
  logic [WIDTH-1:0] amt_q;
  logic [WIDTH-1:0] bal_q [NUM_ACCT];
  logic [CW-1:0]    cnt_q [NUM_ACCT];

  logic             src_ok, dst_ok, same_acct;
  logic [AW-1:0]    src_idx, dst_idx;
  status_e          status;
  logic [WIDTH-1:0] new_src, new_dst;
  logic             cnt_inc;

  // Ids are range-checked so a non-power-of-two NUM_ACCT never reads past the array.
  assign src_ok    = int'(acct_q) < NUM_ACCT;
  assign dst_ok    = int'(dst_q) < NUM_ACCT;
  assign src_idx   = src_ok ? acct_q : '0;
  assign dst_idx   = dst_ok ? dst_q : '0;
  assign same_acct = (acct_q == dst_q);

  atm_txn_check #(
    .WIDTH  (WIDTH),
    .MAX_WD (MAX_WD),
    .CW     (CW)
  ) u_check (
    .op        (op_q),
    .src_bal   (bal_q[src_idx]),
    .dst_bal   (bal_q[dst_idx]),
    .amount    (amt_q),
    .wd_cnt    (cnt_q[src_idx]),
    .src_ok    (src_ok),
    .dst_ok    (dst_ok),
    .same_acct (same_acct),
    .status    (status),
    .new_src   (new_src),
    .new_dst   (new_dst),
    .cnt_inc   (cnt_inc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    txn_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        txn_ready = 1'b1;
        if (txn_valid) state_d = S_EXEC;
      end
      S_EXEC: state_d = S_RESP;
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request fields are captured on the accept edge so the check sees stable inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= OP_DEPOSIT;
      acct_q <= '0;
      dst_q  <= '0;
      amt_q  <= '0;
    end else if ((state_q == S_IDLE) && txn_valid) begin
      op_q   <= op_e'(txn_op);
      acct_q <= txn_acct;
      dst_q  <= txn_dst;
      amt_q  <= txn_amount;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_ACCT; i++) begin
        bal_q[i] <= '0;
        cnt_q[i] <= '0;
      end
      resp_status  <= '0;
      resp_balance <= '0;
      led_ovf      <= 1'b0;
      led_insuf    <= 1'b0;
    end else begin
      if (state_q == S_EXEC) begin
        if (status == ST_OK) begin
          bal_q[src_idx] <= new_src;
          if ((op_q == OP_TRANSFER) && !same_acct) bal_q[dst_idx] <= new_dst;
          if (cnt_inc) cnt_q[src_idx] <= cnt_q[src_idx] + CW'(1);
        end
        resp_status  <= status;
        resp_balance <= (status == ST_BAD_ACCT) ? '0 : new_src;
        // Queries never touch the LEDs; LIMIT and BAD_ACCT fall through unchanged.
        if (op_q != OP_QUERY) begin
          case (status)
            ST_OK: begin
              led_ovf   <= 1'b0;
              led_insuf <= 1'b0;
            end
            ST_OVERFLOW: begin
              led_ovf   <= 1'b1;
              led_insuf <= 1'b0;
            end
            ST_INSUFFICIENT: begin
              led_ovf   <= 1'b0;
              led_insuf <= 1'b1;
            end
            default: ;
          endcase
        end
      end
      // Placed last so a coincident commit increment loses to the daily clear.
      if (day_clear) begin
        for (int i = 0; i < NUM_ACCT; i++) cnt_q[i] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_atm_account_ledger.sv
module tb_atm_account_ledger;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int AW = 2;
  localparam int MX = 3;
  localparam int BAL_MAX = 255;

  logic          clk = 1'b0;
  logic          rst;
  logic          txn_valid;
  logic          txn_ready;
  logic [1:0]    txn_op;
  logic [AW-1:0] txn_acct;
  logic [AW-1:0] txn_dst;
  logic [W-1:0]  txn_amount;
  logic          day_clear;
  logic          resp_valid;
  logic          resp_ready;
  logic [2:0]    resp_status;
  logic [W-1:0]  resp_balance;
  logic          led_ovf;
  logic          led_insuf;

  atm_account_ledger #(.WIDTH(W), .NUM_ACCT(N), .MAX_WD(MX)) dut (
    .clk          (clk),
    .rst          (rst),
    .txn_valid    (txn_valid),
    .txn_ready    (txn_ready),
    .txn_op       (txn_op),
    .txn_acct     (txn_acct),
    .txn_dst      (txn_dst),
    .txn_amount   (txn_amount),
    .day_clear    (day_clear),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_status  (resp_status),
    .resp_balance (resp_balance),
    .led_ovf      (led_ovf),
    .led_insuf    (led_insuf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference ledger: plain integer balances, counters and LED flags.
  int m_bal [N];
  int m_cnt [N];
  int m_ovf, m_insuf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_bal[i] = 0;
      m_cnt[i] = 0;
    end
    m_ovf = 0;
    m_insuf = 0;
  endtask

  // Status codes: 0 OK, 1 OVERFLOW, 2 INSUFFICIENT, 3 BAD_ACCT, 4 LIMIT.
  task automatic model(input int op, input int acct, input int dst, input int amt,
                       output int st, output int rb);
    bit debit;
    debit = (op == 1) || (op == 3);
    st = 0;
    if (acct >= N || (op == 3 && dst >= N)) begin
      st = 3;
      rb = 0;
      return;
    end
    if (debit && m_cnt[acct] >= MX) st = 4;
    else if (debit && amt > m_bal[acct]) st = 2;
    else if (op == 0 && m_bal[acct] + amt > BAL_MAX) st = 1;
    else if (op == 3 && dst != acct && m_bal[dst] + amt > BAL_MAX) st = 1;
    if (st == 0) begin
      if (op == 0) m_bal[acct] += amt;
      if (op == 1 || op == 3) begin
        m_bal[acct] -= amt;
        m_cnt[acct] += 1;
      end
      if (op == 3) m_bal[dst] += amt;
    end
    if (op != 2) begin
      if (st == 0) begin m_ovf = 0; m_insuf = 0; end
      if (st == 1) begin m_ovf = 1; m_insuf = 0; end
      if (st == 2) begin m_ovf = 0; m_insuf = 1; end
    end
    rb = m_bal[acct];
  endtask

  // Runs one full transaction; hold = extra cycles resp_ready stays low,
  // clr_exec = pulse day_clear so it lands on the commit edge.
  task automatic send(input int op, input int acct, input int dst, input int amt,
                      input int hold, input bit clr_exec);
    int st, rb;
    @(negedge clk);
    chk("txn_ready_idle", txn_ready, 1);
    txn_valid  = 1'b1;
    txn_op     = op[1:0];
    txn_acct   = acct[AW-1:0];
    txn_dst    = dst[AW-1:0];
    txn_amount = amt[W-1:0];
    @(posedge clk);
    #1;
    txn_valid = 1'b0;
    if (clr_exec) day_clear = 1'b1;
    model(op, acct, dst, amt, st, rb);
    if (clr_exec) for (int i = 0; i < N; i++) m_cnt[i] = 0;
    @(negedge clk);
    chk("exec_resp_valid", resp_valid, 0);
    chk("exec_txn_ready", txn_ready, 0);
    @(posedge clk);
    #1;
    day_clear = 1'b0;
    @(negedge clk);
    chk("resp_valid", resp_valid, 1);
    chk("resp_status", resp_status, st);
    chk("resp_balance", resp_balance, rb);
    chk("led_ovf", led_ovf, m_ovf);
    chk("led_insuf", led_insuf, m_insuf);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      chk("hold_resp_valid", resp_valid, 1);
      chk("hold_txn_ready", txn_ready, 0);
      chk("hold_status", resp_status, st);
      chk("hold_balance", resp_balance, rb);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    day_clear = 1'b1;
    @(posedge clk);
    #1;
    day_clear = 1'b0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  initial begin
    rst = 1'b1;
    txn_valid = 1'b0;
    txn_op = '0;
    txn_acct = '0;
    txn_dst = '0;
    txn_amount = '0;
    day_clear = 1'b0;
    resp_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_txn_ready", txn_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_status", resp_status, 0);
    chk("rst_resp_balance", resp_balance, 0);
    chk("rst_led_ovf", led_ovf, 0);
    chk("rst_led_insuf", led_insuf, 0);
    rst = 1'b0;

    // Deposit up to the ceiling, then one past it.
    send(0, 1, 0, 200, 0, 0);
    chk("dep200_bal", resp_balance, 200);
    send(0, 1, 0, 55, 0, 0);
    chk("dep255_bal", resp_balance, 255);
    send(0, 1, 0, 1, 0, 0);
    chk("dep_ovf_status", resp_status, 1);
    chk("dep_ovf_bal", resp_balance, 255);
    chk("dep_ovf_led", led_ovf, 1);

    // Insufficient funds then an exact withdrawal.
    send(0, 2, 0, 10, 0, 0);
    send(1, 2, 0, 11, 0, 0);
    chk("wd_insuf_status", resp_status, 2);
    chk("wd_insuf_led", led_insuf, 1);
    chk("wd_insuf_ovf", led_ovf, 0);
    send(1, 2, 0, 10, 0, 0);
    chk("wd_exact_bal", resp_balance, 0);

    // Transfer overflow at the destination, then a fitting transfer.
    send(0, 0, 0, 100, 0, 0);
    send(0, 3, 0, 250, 0, 0);
    send(3, 0, 3, 6, 0, 0);
    chk("xfer_ovf_status", resp_status, 1);
    chk("xfer_ovf_src", resp_balance, 100);
    send(3, 0, 3, 5, 0, 0);
    chk("xfer_ok_src", resp_balance, 95);
    send(2, 3, 0, 0, 0, 0);
    chk("xfer_ok_dst", resp_balance, 255);

    // Withdrawal limit and daily clear.
    pulse_clear();
    for (int i = 0; i < MX; i++) send(1, 0, 0, 1, 0, 0);
    send(1, 0, 0, 1, 0, 0);
    chk("limit_status", resp_status, 4);
    chk("limit_bal", resp_balance, 92);
    pulse_clear();
    send(1, 0, 0, 1, 0, 0);
    chk("after_clear_status", resp_status, 0);

    // Self-transfer, zero amounts, clear coinciding with commit.
    send(3, 0, 0, 7, 0, 0);
    send(1, 2, 0, 0, 0, 0);
    send(3, 1, 0, 0, 0, 0);
    send(1, 0, 0, 1, 0, 1);
    send(1, 0, 0, 1, 0, 0);
    send(1, 0, 0, 1, 0, 0);
    send(1, 0, 0, 1, 0, 0);

    // Response backpressure.
    send(2, 1, 0, 0, 5, 0);
    send(0, 2, 0, 3, 0, 0);

    // Reset during EXEC of a transfer.
    @(negedge clk);
    txn_valid = 1'b1;
    txn_op = 2'd3;
    txn_acct = 2'd0;
    txn_dst = 2'd1;
    txn_amount = 8'd1;
    @(posedge clk);
    #1;
    txn_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_txn_ready", txn_ready, 1);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_status", resp_status, 0);
    chk("midrst_balance", resp_balance, 0);
    chk("midrst_led_ovf", led_ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int a = 0; a < N; a++) begin
      send(2, a, 0, 0, 0, 0);
      chk("midrst_bal_zero", resp_balance, 0);
    end

    // Randomised traffic against the reference ledger.
    for (int t = 0; t < 300; t++) begin
      int op, acct, dst, amt, hold;
      op   = int'($urandom_range(0, 3));
      acct = int'($urandom_range(0, N - 1));
      dst  = int'($urandom_range(0, N - 1));
      amt  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 255))
                                         : int'($urandom_range(0, 20));
      hold = int'($urandom_range(0, 3));
      send(op, acct, dst, amt, hold, ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 14) == 0) pulse_clear();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
